led_pattern_ctrl: RTL
=====================

Name: led_pattern_ctrl

Overview:
- Button-driven scheduler for the 8-LED bank on the STEPFPGA board.
- Three push keys set the lighting pattern, set the step speed, and pause/resume the sequence.
- Sits between the raw board keys and the active-low LED pins, in place of a fixed-sequence chaser.
- Owns the step timebase and the position/direction state that each pattern walks through.

Parameters:
- BASE_CNT, 600000: clk cycles per step at speed 0 (50 ms at 12 MHz).
- DEB_CNT, 240000: cycles a key level must stay stable before it is accepted (20 ms).
- CNT_W, $clog2(BASE_CNT*8): width of the step counter; holds the slowest period.

Ports:
- clk  input  1  system clock, 12 MHz
- rst_n  input  1  asynchronous active-low reset
- key_mode_n  input  1  raw key, active-low; a press cycles the pattern
- key_speed_n  input  1  raw key, active-low; a press cycles the speed
- key_pause_n  input  1  raw key, active-low; a press toggles pause
- LEDs  output  8  LED drive, active-low (0 = lit)
- mode  output  2  current pattern
- speed  output  2  current speed level
- paused  output  1  high while frozen

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. rst_n low sets:
  - LEDs=8'hFF, mode=0, speed=0, paused=0
  - pos=0, dir=up, phase=0, step counter=0
  - debouncers idle, key levels assumed released
- Key path, per key:
  - 2-flop synchronizer.
  - Debounce counter: a new level is accepted only after DEB_CNT consecutive equal samples.
  - An accepted high-to-low transition gives a 1-cycle press pulse. Release gives no pulse.
- Step period = BASE_CNT << speed:
  - speed 0 = 50 ms, speed 1 = 100 ms, speed 2 = 200 ms, speed 3 = 400 ms.
  - tick is high for one cycle when cnt == period-1; cnt then wraps to 0.
  - While paused, cnt and all pattern state hold.
- Pattern state (pos 0..7, dir, phase) advances on tick:
  - mode 0, chase-left: pos+1, wraps 7->0.
  - mode 1, chase-right: pos-1, wraps 0->7.
  - mode 2, bounce: sequence 0,1,...,7,6,...,1,0,1,... Dir flips on the tick that reaches 7 or 0. End LEDs are never repeated.
  - mode 3, blink-all: phase toggles; pos is unused.
- LED output is registered, with 1-cycle latency from the state change:
  - modes 0-2: LEDs = ~(8'b1 << pos)
  - mode 3: LEDs = phase ? 8'hFF : 8'h00
- Mode press: mode+1 (wraps 3->0); pos=0, dir=up, phase=0, cnt=0. Pause state is kept.
- Speed press: speed+1 (wraps 3->0); cnt=0; pos, dir and phase are kept.
- Pause press: paused toggles; cnt is kept, so resume continues the partial interval.
- Same-cycle events, resolved in this order:
  - mode press overrides a same-cycle tick (reset-to-start wins).
  - speed press clears cnt, which suppresses a same-cycle tick.
  - Simultaneous presses all apply in the same cycle.
- Reset mid-debounce or mid-step discards all progress. After reset deasserts, the first LED update (8'hFE) appears on the first clk edge.

Optional Feature:
- Macro PAUSE_BLINK_EN.
- When defined: while paused, a free-running counter toggles a blank flag every 4*BASE_CNT cycles.
  - LEDs shows 8'hFF when blank=1, otherwise the frozen pattern.
  - blank clears on resume.
- When undefined: while paused, LEDs holds the frozen pattern steadily, and no extra counter is synthesized.

Decomposition:
- Shared package led_pkg holds:
  - mode encodings MODE_CHASE_L=0, MODE_CHASE_R=1, MODE_BOUNCE=2, MODE_BLINK=3
  - LED_ALL_OFF=8'hFF and LED_ALL_ON=8'h00
- One sub-module, key_debounce (sync + debounce + press pulse, parameter DEB_CNT), instantiated three times.
- Timebase, pattern FSM and output register stay in the top module.

Test Plan:
All scenarios use BASE_CNT=4, DEB_CNT=3.
1. Reset release, no keys. Required: LEDs=FE one cycle after release, then FD, FB, ... 7F, FE, with a step every 4 cycles.
2. Press key_mode_n twice (bounce). Required: LEDs walk FE..7F, then BF, DF, ..., FE, then FD; no duplicate 7F or FE.
3. Press speed 3 times. Required: speed=3, steps spaced exactly 32 cycles. A key low for only 2 cycles is ignored, with no speed change.
4. Pause mid-interval at cnt=2, hold 50 cycles, then resume. Required: LEDs is constant while paused; the next step comes 2 cycles after resume.
5. Mode press and tick in the same cycle. Required: pos resets, LEDs=FE, no advance.
6. PAUSE_BLINK_EN defined: pause in mode 0 at pos 3. Required: LEDs alternates F7/FF every 16 cycles; returns to F7 on resume.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings and constants for the LED pattern controller.
package led_pkg;

    localparam int unsigned LED_W = 8;

    typedef enum logic [1:0] {
        MODE_CHASE_L = 2'd0,
        MODE_CHASE_R = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    localparam logic [LED_W-1:0] LED_ALL_OFF = 8'hFF;
    localparam logic [LED_W-1:0] LED_ALL_ON  = 8'h00;

    // Active-low drive with only the LED at pos lit.
    function automatic logic [LED_W-1:0] led_single(input logic [2:0] pos);
        return ~(8'b1 << pos);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key: 2-flop synchronizer, level debounce, 1-cycle press pulse.
module key_debounce #(
    parameter int unsigned DEB_CNT = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CNT - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Synchronizer; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level after DEB_CNT consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    // Debounce state and press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Key-driven pattern scheduler for the 8-LED bank (active-low LEDs).
// Optional feature macro PAUSE_BLINK_EN: blanks the frozen pattern periodically while paused.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned BASE_CNT = 600000,
    parameter int unsigned DEB_CNT  = 240000,
    parameter int unsigned CNT_W    = $clog2(BASE_CNT * 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_mode_n,
    input  logic             key_speed_n,
    input  logic             key_pause_n,
    output logic [LED_W-1:0] LEDs,
    output logic [1:0]       mode,
    output logic [1:0]       speed,
    output logic             paused
);

    logic mode_press, speed_press, pause_press;

    key_debounce #(.DEB_CNT(DEB_CNT)) u_key_mode (
        .clk(clk), .rst_n(rst_n), .key_n_i(key_mode_n), .press_o(mode_press)
    );
    key_debounce #(.DEB_CNT(DEB_CNT)) u_key_speed (
        .clk(clk), .rst_n(rst_n), .key_n_i(key_speed_n), .press_o(speed_press)
    );
    key_debounce #(.DEB_CNT(DEB_CNT)) u_key_pause (
        .clk(clk), .rst_n(rst_n), .key_n_i(key_pause_n), .press_o(pause_press)
    );

    mode_e            mode_q, mode_d;
    logic [1:0]       speed_q, speed_d;
    logic             paused_q, paused_d;
    logic [2:0]       pos_q, pos_d;
    logic             dir_up_q, dir_up_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      period_c;
    logic [CNT_W-1:0] period_last_c;
    logic             tick_c;

    assign period_c      = BASE_CNT << speed_q;
    assign period_last_c = CNT_W'(period_c - 32'd1);

    // Step tick; a mode or speed press restarts the interval instead.
    assign tick_c = !paused_q && (cnt_q == period_last_c) && !mode_press && !speed_press;

`ifdef PAUSE_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(4 * BASE_CNT);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(4 * BASE_CNT - 1);

    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    logic               blank_q, blank_d;

    // Free-running blank toggle while paused; cleared as soon as the sequence resumes.
    always_comb begin
        bcnt_d  = bcnt_q;
        blank_d = blank_q;
        if (!paused_d) begin
            bcnt_d  = '0;
            blank_d = 1'b0;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            blank_d = ~blank_q;
        end else begin
            bcnt_d = bcnt_q + BLINK_W'(1);
        end
    end

    // Blank timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            blank_q <= blank_d;
        end
    end
`endif

    // Next-state: timebase, pattern walk, key actions and LED image.
    always_comb begin
        mode_d   = mode_q;
        speed_d  = speed_q;
        paused_d = paused_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;

        if (mode_press || speed_press) begin
            cnt_d = '0;
        end else if (!paused_q) begin
            cnt_d = (cnt_q == period_last_c) ? '0 : cnt_q + CNT_W'(1);
        end

        if (tick_c) begin
            case (mode_q)
                MODE_CHASE_L: pos_d = pos_q + 3'd1;
                MODE_CHASE_R: pos_d = pos_q - 3'd1;
                MODE_BOUNCE: begin
                    if (dir_up_q) begin
                        pos_d = pos_q + 3'd1;
                        if (pos_q == 3'd6) dir_up_d = 1'b0;
                    end else begin
                        pos_d = pos_q - 3'd1;
                        if (pos_q == 3'd1) dir_up_d = 1'b1;
                    end
                end
                MODE_BLINK:   phase_d = ~phase_q;
                default: ;
            endcase
        end

        if (pause_press) paused_d = ~paused_q;
        if (speed_press) speed_d = speed_q + 2'd1;
        if (mode_press) begin
            mode_d   = mode_e'(mode_q + 2'd1);
            pos_d    = 3'd0;
            dir_up_d = 1'b1;
            phase_d  = 1'b0;
        end

        if (mode_q == MODE_BLINK) begin
            led_d = phase_q ? LED_ALL_OFF : LED_ALL_ON;
        end else begin
            led_d = led_single(pos_q);
        end
`ifdef PAUSE_BLINK_EN
        if (blank_q) led_d = LED_ALL_OFF;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_CHASE_L;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
            pos_q    <= 3'd0;
            dir_up_q <= 1'b1;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            led_q    <= LED_ALL_OFF;
        end else begin
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
        end
    end

    assign LEDs   = led_q;
    assign mode   = mode_q;
    assign speed  = speed_q;
    assign paused = paused_q;

endmodule
